// File: rtl/psram_qpi_responder.sv
// QPI PSRAM responder: decodes SPI reset/mode-switch commands, then serves QPI quad read (0xEB)
// and quad write (0x38) bursts from an internal byte array. Inputs sampled on posedge, read
// data launched on negedge.
module psram_qpi_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 7
) (
  input  logic       mem_clk,
  input  logic       rst_n,
  input  logic       mem_ce,
  inout  wire  [3:0] mem_sio,
  output logic       qpi_mode,
  output logic       rsten_armed,
  output logic [7:0] last_cmd,
  output logic       busy
);

  localparam int unsigned Depth   = 2 ** ADDR_BITS;
  localparam int unsigned SlotMax = 8 + WAIT_CYCLES;
  localparam int unsigned SlotW   = $clog2(SlotMax + 1);

  localparam logic [SlotW-1:0] SlotCmdEnd = SlotW'(7);
  localparam logic [SlotW-1:0] SlotLastDm = SlotW'(7 + WAIT_CYCLES);
  localparam logic [SlotW-1:0] SlotSat    = SlotW'(SlotMax);

  typedef enum logic [2:0] {
    StIdle, StSpiCmd, StQpiCmd, StAddr, StWait, StRdata, StWdata, StIgnore
  } state_e;

  state_e               state_q, state_d;
  logic [SlotW-1:0]     slot_q, slot_d;
  logic [6:0]           sr_q, sr_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 phase_q, phase_d;
  logic [3:0]           hi_q, hi_d;
  logic                 qpi_q, qpi_d;
  logic                 armed_q, armed_d;
  logic [7:0]           last_cmd_q, last_cmd_d;
  logic                 is_rd_q, is_rd_d;

  logic [7:0]           cmd_byte;
  logic                 cmd_done;
  logic                 mem_we;
  logic [7:0]           rd_byte;
  logic                 drive_en_q;
  logic [3:0]           out_q;

  logic [7:0]           mem_q [Depth];

  // State register
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state: CE high always returns to idle; otherwise advance by slot position
  always_comb begin
    state_d = state_q;
    if (mem_ce) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   state_d = qpi_q ? StQpiCmd : StSpiCmd;
        StSpiCmd: if (slot_q == SlotCmdEnd) state_d = StIgnore;
        StQpiCmd: state_d = (cmd_byte == 8'hEB || cmd_byte == 8'h38) ? StAddr : StIgnore;
        StAddr: begin
          if (slot_q == SlotCmdEnd) begin
            if (!is_rd_q)              state_d = StWdata;
            else if (WAIT_CYCLES == 0) state_d = StRdata;
            else                       state_d = StWait;
          end
        end
        StWait:   if (slot_q == SlotLastDm) state_d = StRdata;
        default:  state_d = state_q;
      endcase
    end
  end

  // Outputs and decode strobes derived from the current state
  always_comb begin
    busy        = (state_q != StIdle);
    qpi_mode    = qpi_q;
    rsten_armed = armed_q;
    last_cmd    = last_cmd_q;
    cmd_byte    = (state_q == StQpiCmd) ? {sr_q[3:0], mem_sio} : {sr_q, mem_sio[0]};
    cmd_done    = ~mem_ce & (((state_q == StSpiCmd) & (slot_q == SlotCmdEnd)) |
                             (state_q == StQpiCmd));
    mem_we      = ~mem_ce & (state_q == StWdata) & phase_q;
  end

  // Datapath next-state: slot count, shifters, byte index, mode/arm flags
  always_comb begin
    slot_d     = slot_q;
    sr_d       = sr_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    qpi_d      = qpi_q;
    armed_d    = armed_q;
    last_cmd_d = last_cmd_q;
    is_rd_d    = is_rd_q;
    if (mem_ce) begin
      slot_d  = '0;
      phase_d = 1'b0;  // drops any unpaired write nibble
    end else begin
      if (slot_q != SlotSat) slot_d = slot_q + SlotW'(1);
      case (state_q)
        StIdle:   sr_d = qpi_q ? {3'b000, mem_sio} : {6'b000000, mem_sio[0]};
        StSpiCmd: sr_d = {sr_q[5:0], mem_sio[0]};
        StAddr:   idx_d = ADDR_BITS'({idx_q, mem_sio});  // upper address bits fall off
        StWdata: begin
          phase_d = ~phase_q;
          if (!phase_q) hi_d  = mem_sio;
          else          idx_d = idx_q + ADDR_BITS'(1);
        end
        StRdata: begin
          phase_d = ~phase_q;
          if (phase_q) idx_d = idx_q + ADDR_BITS'(1);
        end
        default: ;
      endcase
      if (cmd_done) begin
        last_cmd_d = cmd_byte;
        armed_d    = 1'b0;
        is_rd_d    = (cmd_byte == 8'hEB);
        case (cmd_byte)
          8'h66: armed_d = 1'b1;
          8'h99: if (armed_q) qpi_d = 1'b0;
          8'h35: if (!qpi_q) qpi_d = 1'b1;
          8'hF5: if (qpi_q) qpi_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Datapath registers
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      sr_q       <= '0;
      idx_q      <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      qpi_q      <= 1'b0;
      armed_q    <= 1'b0;
      last_cmd_q <= 8'h00;
      is_rd_q    <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      sr_q       <= sr_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      qpi_q      <= qpi_d;
      armed_q    <= armed_d;
      last_cmd_q <= last_cmd_d;
      is_rd_q    <= is_rd_d;
    end
  end

  // Byte array; contents survive reset
  always_ff @(posedge mem_clk) begin
    if (mem_we) mem_q[idx_q] <= {hi_q, mem_sio};
  end

  assign rd_byte = mem_q[idx_q];

  // Launch read nibbles on negedge so they are stable across the following posedge
  always_ff @(negedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_en_q <= 1'b0;
      out_q      <= '0;
    end else begin
      drive_en_q <= (state_q == StRdata);
      out_q      <= phase_q ? rd_byte[3:0] : rd_byte[7:4];
    end
  end

  assign mem_sio = (drive_en_q & ~mem_ce) ? out_q : 4'bzzzz;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder. A pull-up on the bus makes an undriven nibble read
// as 4'hF; test data avoids F where a released bus must be distinguished from driven data.
module tb_psram_qpi_responder;

  localparam int unsigned AddrBits = 8;
  localparam int unsigned WaitCyc  = 7;

  logic       mem_clk;
  logic       rst_n;
  logic       mem_ce;
  wire  [3:0] mem_sio;
  logic       qpi_mode;
  logic       rsten_armed;
  logic [7:0] last_cmd;
  logic       busy;

  logic [3:0] tb_sio;
  logic       tb_oe;

  int n_checks = 0;
  int n_errors = 0;

  assign mem_sio = tb_oe ? tb_sio : 4'bzzzz;
  pullup (mem_sio[0]);
  pullup (mem_sio[1]);
  pullup (mem_sio[2]);
  pullup (mem_sio[3]);

  psram_qpi_responder #(
    .ADDR_BITS   (AddrBits),
    .WAIT_CYCLES (WaitCyc)
  ) dut (
    .mem_clk     (mem_clk),
    .rst_n       (rst_n),
    .mem_ce      (mem_ce),
    .mem_sio     (mem_sio),
    .qpi_mode    (qpi_mode),
    .rsten_armed (rsten_armed),
    .last_cmd    (last_cmd),
    .busy        (busy)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One CE-low slot; starts just after a negedge, samples the bus 1 ns after the posedge
  task automatic tick(input logic [3:0] nib, input logic oe, output logic [3:0] seen);
    mem_ce = 1'b0;
    tb_sio = nib;
    tb_oe  = oe;
    @(posedge mem_clk);
    #1 seen = mem_sio;
    @(negedge mem_clk);
  endtask

  task automatic ce_high(input int n);
    mem_ce = 1'b1;
    tb_oe  = 1'b0;
    repeat (n) begin
      @(posedge mem_clk);
      @(negedge mem_clk);
    end
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    logic [3:0] s;
    for (int i = 7; i >= 0; i--) begin
      tick({3'b000, b[i]}, 1'b1, s);
      if (i == 7) check("spi_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic qpi_cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [3:0] s;
    tick(cmd[7:4], 1'b1, s);
    tick(cmd[3:0], 1'b1, s);
    for (int i = 5; i >= 0; i--) tick(addr[4*i +: 4], 1'b1, s);
  endtask

  // Writes n nibbles taken MSN-first from the left of data
  task automatic qpi_write(input logic [23:0] addr, input logic [31:0] data, input int n);
    logic [3:0] s;
    qpi_cmd_addr(8'h38, addr);
    for (int k = 0; k < n; k++) tick(data[31-4*k -: 4], 1'b1, s);
    ce_high(2);
  endtask

  task automatic dummies(input int n);
    logic [3:0] s;
    for (int k = 0; k < n; k++) begin
      tick(4'h0, 1'b0, s);
      check("dummy_z", {28'd0, s}, 32'hF);
    end
  endtask

  // Reads n nibbles, returned right-aligned MSN-first
  task automatic qpi_read(input logic [23:0] addr, input int n, output logic [31:0] got);
    logic [3:0] s;
    got = '0;
    qpi_cmd_addr(8'hEB, addr);
    dummies(WaitCyc);
    for (int k = 0; k < n; k++) begin
      tick(4'h0, 1'b0, s);
      got = {got[27:0], s};
    end
    ce_high(2);
  endtask

  logic [31:0] rd;
  logic [3:0]  s;

  initial begin
    rst_n  = 1'b0;
    mem_ce = 1'b1;
    tb_oe  = 1'b0;
    tb_sio = 4'h0;
    repeat (2) @(negedge mem_clk);
    check("rst_qpi",   {31'd0, qpi_mode},    32'd0);
    check("rst_armed", {31'd0, rsten_armed}, 32'd0);
    check("rst_last",  {24'd0, last_cmd},    32'h00);
    check("rst_busy",  {31'd0, busy},        32'd0);
    check("rst_bus_z", {28'd0, mem_sio},     32'hF);
    rst_n = 1'b1;
    ce_high(2);

    // SPI reset-enable / reset, then mode switch
    spi_cmd(8'h66);
    check("armed_set", {31'd0, rsten_armed}, 32'd1);
    check("last_66",   {24'd0, last_cmd},    32'h66);
    ce_high(1);
    check("busy_fall", {31'd0, busy}, 32'd0);
    spi_cmd(8'h99);
    check("armed_clr", {31'd0, rsten_armed}, 32'd0);
    check("qpi_after_rst", {31'd0, qpi_mode}, 32'd0);
    check("last_99",   {24'd0, last_cmd},    32'h99);
    ce_high(2);
    spi_cmd(8'h35);
    check("qpi_on",  {31'd0, qpi_mode}, 32'd1);
    check("last_35", {24'd0, last_cmd}, 32'h35);
    ce_high(2);

    // Basic write then read with first data at slot 15
    qpi_write(24'h000010, 32'hA5C3_0000, 4);
    check("last_38", {24'd0, last_cmd}, 32'h38);
    qpi_read(24'h000010, 4, rd);
    check("rd_a5c3", rd, 32'h0000_A5C3);
    check("last_eb", {24'd0, last_cmd}, 32'hEB);

    // Index wrap at top of array
    qpi_write(24'h0000FF, 32'hBEEF_0000, 4);
    qpi_read(24'h0000FF, 4, rd);
    check("rd_wrap", rd, 32'h0000_BEEF);
    qpi_read(24'h000000, 2, rd);
    check("rd_idx0", rd, 32'h0000_00EF);

    // Unpaired trailing nibble is dropped
    qpi_write(24'h000020, 32'h7788_0000, 4);
    qpi_write(24'h000020, 32'h1230_0000, 3);
    qpi_read(24'h000020, 4, rd);
    check("rd_partial", rd, 32'h0000_1288);

    // CE rises during slot 16 of a read
    qpi_cmd_addr(8'hEB, 24'h000010);
    dummies(WaitCyc);
    tick(4'h0, 1'b0, s);
    check("abort_s15", {28'd0, s}, 32'hA);
    mem_ce = 1'b0;
    @(posedge mem_clk);
    #1 check("abort_s16", {28'd0, mem_sio}, 32'h5);
    check("abort_busy", {31'd0, busy}, 32'd1);
    #1 mem_ce = 1'b1;
    #1 check("abort_bus_z", {28'd0, mem_sio}, 32'hF);
    @(posedge mem_clk);
    #1 check("abort_busy_fall", {31'd0, busy}, 32'd0);
    @(negedge mem_clk);
    ce_high(1);
    qpi_read(24'h000020, 2, rd);
    check("rd_after_abort", rd, 32'h0000_0012);

    // Async reset during the WAIT phase of a read
    qpi_write(24'h000030, 32'h6942_0000, 4);
    qpi_cmd_addr(8'hEB, 24'h000030);
    dummies(3);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_qpi",  {31'd0, qpi_mode}, 32'd0);
    check("mid_rst_busy", {31'd0, busy},     32'd0);
    check("mid_rst_last", {24'd0, last_cmd}, 32'h00);
    check("mid_rst_bus",  {28'd0, mem_sio},  32'hF);
    @(negedge mem_clk);
    mem_ce = 1'b1;
    @(negedge mem_clk);
    rst_n = 1'b1;
    ce_high(2);
    spi_cmd(8'h35);
    check("qpi_reenable", {31'd0, qpi_mode}, 32'd1);
    ce_high(2);
    qpi_read(24'h000010, 4, rd);
    check("rd_kept_10", rd, 32'h0000_A5C3);
    qpi_read(24'h000030, 4, rd);
    check("rd_kept_30", rd, 32'h0000_6942);

    // QPI exit command
    qpi_cmd_addr(8'hF5, 24'h000000);
    check("last_f5", {24'd0, last_cmd}, 32'hF5);
    check("qpi_exit", {31'd0, qpi_mode}, 32'd0);
    ce_high(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
